// File: rtl/vram_arbiter_if.sv
// Request/response bundle between the video fetch path, the CPU bridge and the VRAM macro.
// The arbiter takes the slave view; requesters and the RAM model take the master view.
interface vram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          vid_req_i;
  logic [AW-1:0] vid_addr_i;
  logic          vid_ack_o;
  logic [DW-1:0] vid_data_o;

  logic          cpu_req_i;
  logic          cpu_we_i;
  logic [AW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_wdata_i;
  logic          cpu_ack_o;
  logic [DW-1:0] cpu_rdata_o;

  logic [AW-1:0] ram_addr_o;
  logic          ram_we_o;
  logic [DW-1:0] ram_wdata_o;
  logic [DW-1:0] ram_rdata_i;

  logic          busy_o;

  modport slave (
    input  vid_req_i, vid_addr_i,
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  ram_rdata_i,
    output vid_ack_o, vid_data_o,
    output cpu_ack_o, cpu_rdata_o,
    output ram_addr_o, ram_we_o, ram_wdata_o,
    output busy_o
  );

  modport master (
    output vid_req_i, vid_addr_i,
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output ram_rdata_i,
    input  vid_ack_o, vid_data_o,
    input  cpu_ack_o, cpu_rdata_o,
    input  ram_addr_o, ram_we_o, ram_wdata_o,
    input  busy_o
  );
endinterface

// File: rtl/vram_arbiter.sv
// Two-requester arbiter for a single-port synchronous VRAM: video reads have priority,
// and every completed access hands the next slot to the other side if it is waiting.
module vram_arbiter #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  vram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    V_ISSUE = 3'd1,
    V_DONE  = 3'd2,
    C_ISSUE = 3'd3,
    C_DONE  = 3'd4
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_ram_addr;
  logic          r_ram_we;
  logic [DW-1:0] r_ram_wdata;
  logic          r_vid_ack;
  logic          r_cpu_ack;
  logic          r_busy;

  // Acks and busy are registered alongside the state so they line up exactly with it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= IDLE;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_vid_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_vid_ack <= 1'b0;
      r_cpu_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.vid_req_i) begin
            r_state    <= V_ISSUE;
            r_ram_addr <= bus.vid_addr_i;
            r_ram_we   <= 1'b0;
            r_busy     <= 1'b1;
          end else if (bus.cpu_req_i) begin
            r_state     <= C_ISSUE;
            r_ram_addr  <= bus.cpu_addr_i;
            r_ram_we    <= bus.cpu_we_i;
            r_ram_wdata <= bus.cpu_wdata_i;
            r_busy      <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        V_ISSUE: begin
          r_state   <= V_DONE;
          r_vid_ack <= 1'b1;
        end
        // The video request is still held here, so only the CPU can win this slot.
        V_DONE: begin
          if (bus.cpu_req_i) begin
            r_state     <= C_ISSUE;
            r_ram_addr  <= bus.cpu_addr_i;
            r_ram_we    <= bus.cpu_we_i;
            r_ram_wdata <= bus.cpu_wdata_i;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        C_ISSUE: begin
          r_state   <= C_DONE;
          r_ram_we  <= 1'b0;
          r_cpu_ack <= 1'b1;
        end
        C_DONE: begin
          if (bus.vid_req_i) begin
            r_state    <= V_ISSUE;
            r_ram_addr <= bus.vid_addr_i;
            r_ram_we   <= 1'b0;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_ram_we <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_addr_o  = r_ram_addr;
  assign bus.ram_we_o    = r_ram_we;
  assign bus.ram_wdata_o = r_ram_wdata;
  assign bus.vid_ack_o   = r_vid_ack;
  assign bus.cpu_ack_o   = r_cpu_ack;
  assign bus.busy_o      = r_busy;

  // Read data is only meaningful while the matching ack is high.
  assign bus.vid_data_o  = bus.ram_rdata_i;
  assign bus.cpu_rdata_o = bus.ram_rdata_i;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed timing scenarios plus randomized two-requester traffic
// checked against a byte-array memory model and the arbitration latency/ordering rules.
module tb_vram_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  vram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  // VRAM macro: samples addr/we/wdata on the rising edge, data out one cycle later
  logic [DW-1:0] vram [0:(1<<AW)-1];
  logic [DW-1:0] ram_rdata_q;
  always @(posedge clk) begin
    if (bus.ram_we_o) vram[bus.ram_addr_o] <= bus.ram_wdata_o;
    ram_rdata_q <= vram[bus.ram_addr_o];
  end
  assign bus.ram_rdata_i = ram_rdata_q;

  // Expected memory contents: written only when the bench sees its own write acknowledged
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [AW-1:0] win();
    return AW'(32'h0200 + $urandom_range(15));
  endfunction

  task automatic idle_inputs();
    bus.vid_req_i   = 1'b0;
    bus.vid_addr_i  = '0;
    bus.cpu_req_i   = 1'b0;
    bus.cpu_we_i    = 1'b0;
    bus.cpu_addr_i  = '0;
    bus.cpu_wdata_i = '0;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (4) @(negedge clk);
  endtask

  // Single CPU access; returns at a negedge with the arbiter back in IDLE
  task automatic cpu_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            output logic [DW-1:0] rdata, output bit ok);
    ok = 1'b0;
    rdata = '0;
    bus.cpu_req_i = 1'b1;
    bus.cpu_we_i = we;
    bus.cpu_addr_i = addr;
    bus.cpu_wdata_i = wdata;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (bus.cpu_ack_o) begin
        ok = 1'b1;
        rdata = bus.cpu_rdata_o;
      end
    end
    bus.cpu_req_i = 1'b0;
    if (ok && we) ref_mem[addr] = wdata;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.ram_addr_o, bus.ram_we_o, bus.ram_wdata_o, bus.vid_ack_o, bus.cpu_ack_o, bus.busy_o} !== '0) begin
      errors++;
      $display("FAIL reset_values: addr=%h we=%b wdata=%h vack=%b cack=%b busy=%b, required all 0",
               bus.ram_addr_o, bus.ram_we_o, bus.ram_wdata_o, bus.vid_ack_o, bus.cpu_ack_o, bus.busy_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    bus.cpu_req_i = 1'b1;
    bus.cpu_we_i = 1'b1;
    bus.cpu_addr_i = 16'h1234;
    bus.cpu_wdata_i = 8'hC3;
    @(negedge clk);
    checks++;
    if (bus.ram_we_o !== 1'b1 || bus.ram_addr_o !== 16'h1234 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_issue: we=%b addr=%h busy=%b, required we=1 addr=1234 busy=1",
               bus.ram_we_o, bus.ram_addr_o, bus.busy_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ram_addr_o, bus.ram_we_o, bus.ram_wdata_o, bus.vid_ack_o, bus.cpu_ack_o, bus.busy_o} !== '0) begin
      errors++;
      $display("FAIL reset_abort: addr=%h we=%b wdata=%h cack=%b busy=%b, required all 0",
               bus.ram_addr_o, bus.ram_we_o, bus.ram_wdata_o, bus.cpu_ack_o, bus.busy_o);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.cpu_ack_o !== 1'b0 || bus.ram_we_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b cack=%b we=%b, required 0 0 0", bus.busy_o, bus.cpu_ack_o, bus.ram_we_o);
    end
    $display("txn reset: aborted write to 1234");
  endtask

  task automatic test_video_read();
    logic [DW-1:0] rd;
    bit ok;
    int gap;
    cpu_access(1'b1, 16'h0123, 8'h5A, rd, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL vid_preload: ack=0, required 1"); end
    bus.vid_req_i = 1'b1;
    bus.vid_addr_i = 16'h0123;
    @(negedge clk);
    checks++;
    if (bus.ram_addr_o !== 16'h0123 || bus.ram_we_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.vid_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL vid_issue: addr=%h we=%b busy=%b vack=%b, required 0123 0 1 0",
               bus.ram_addr_o, bus.ram_we_o, bus.busy_o, bus.vid_ack_o);
    end
    @(negedge clk);
    checks++;
    if (bus.vid_ack_o !== 1'b1 || bus.vid_data_o !== 8'h5A) begin
      errors++;
      $display("FAIL vid_first_ack: vack=%b data=%h, required 1 5a", bus.vid_ack_o, bus.vid_data_o);
    end
    for (int n = 0; n < 2; n++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!bus.vid_ack_o && gap < 10);
      checks++;
      if (gap != 3 || bus.vid_data_o !== 8'h5A) begin
        errors++;
        $display("FAIL vid_stream_gap: gap=%0d data=%h, required 3 5a", gap, bus.vid_data_o);
      end
    end
    bus.vid_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL vid_idle_busy: busy=%b, required 0", bus.busy_o); end
    $display("txn video: 3 reads of 0123");
    drain();
  endtask

  task automatic test_cpu_write_read();
    bus.cpu_req_i = 1'b1;
    bus.cpu_we_i = 1'b1;
    bus.cpu_addr_i = 16'h4000;
    bus.cpu_wdata_i = 8'hA5;
    @(negedge clk);
    checks++;
    if (bus.ram_we_o !== 1'b1 || bus.ram_wdata_o !== 8'hA5 || bus.ram_addr_o !== 16'h4000 || bus.cpu_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL cpu_wr_issue: we=%b wdata=%h addr=%h cack=%b, required 1 a5 4000 0",
               bus.ram_we_o, bus.ram_wdata_o, bus.ram_addr_o, bus.cpu_ack_o);
    end
    @(negedge clk);
    checks++;
    if (bus.cpu_ack_o !== 1'b1 || bus.ram_we_o !== 1'b0) begin
      errors++;
      $display("FAIL cpu_wr_ack: cack=%b we=%b, required 1 0", bus.cpu_ack_o, bus.ram_we_o);
    end
    if (bus.cpu_ack_o) ref_mem[16'h4000] = 8'hA5;
    bus.cpu_req_i = 1'b0;
    @(negedge clk);
    bus.cpu_req_i = 1'b1;
    bus.cpu_we_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ram_we_o !== 1'b0 || bus.cpu_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL cpu_rd_issue: we=%b cack=%b, required 0 0", bus.ram_we_o, bus.cpu_ack_o);
    end
    @(negedge clk);
    checks++;
    if (bus.cpu_ack_o !== 1'b1 || bus.cpu_rdata_o !== 8'hA5) begin
      errors++;
      $display("FAIL cpu_rd_ack: cack=%b rdata=%h, required 1 a5", bus.cpu_ack_o, bus.cpu_rdata_o);
    end
    $display("txn cpu: write a5 then read 4000");
    drain();
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] rd;
    bit ok;
    cpu_access(1'b1, 16'h0010, 8'h3C, rd, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL simul_preload: ack=0, required 1"); end
    bus.vid_req_i = 1'b1;
    bus.vid_addr_i = 16'h0123;
    bus.cpu_req_i = 1'b1;
    bus.cpu_we_i = 1'b0;
    bus.cpu_addr_i = 16'h0010;
    @(negedge clk);
    checks++;
    if (bus.ram_addr_o !== 16'h0123 || bus.vid_ack_o !== 1'b0 || bus.cpu_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL simul_v_issue: addr=%h vack=%b cack=%b, required 0123 0 0", bus.ram_addr_o, bus.vid_ack_o, bus.cpu_ack_o);
    end
    @(negedge clk);
    checks++;
    if (bus.vid_ack_o !== 1'b1 || bus.vid_data_o !== 8'h5A || bus.cpu_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL simul_v_done: vack=%b data=%h cack=%b, required 1 5a 0", bus.vid_ack_o, bus.vid_data_o, bus.cpu_ack_o);
    end
    bus.vid_req_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ram_addr_o !== 16'h0010 || bus.ram_we_o !== 1'b0 || bus.vid_ack_o !== 1'b0 || bus.cpu_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL simul_c_issue: addr=%h we=%b vack=%b cack=%b, required 0010 0 0 0",
               bus.ram_addr_o, bus.ram_we_o, bus.vid_ack_o, bus.cpu_ack_o);
    end
    @(negedge clk);
    checks++;
    if (bus.cpu_ack_o !== 1'b1 || bus.cpu_rdata_o !== 8'h3C) begin
      errors++;
      $display("FAIL simul_c_done: cack=%b rdata=%h, required 1 3c", bus.cpu_ack_o, bus.cpu_rdata_o);
    end
    $display("txn simultaneous: video 0123 then cpu 0010");
    drain();
  endtask

  task automatic test_contention();
    logic [DW-1:0] rd;
    bit ok;
    logic [AW-1:0] va, ca;
    int last_owner, last_cyc, n_acks, owner;
    for (int i = 0; i < 16; i++) begin
      cpu_access(1'b1, AW'(32'h0200 + i), DW'($urandom), rd, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL window_prewrite: addr=%h ack=0, required 1", AW'(32'h0200 + i)); end
    end
    va = win();
    ca = win();
    bus.vid_req_i = 1'b1;
    bus.vid_addr_i = va;
    bus.cpu_req_i = 1'b1;
    bus.cpu_we_i = 1'b0;
    bus.cpu_addr_i = ca;
    last_owner = 1;
    last_cyc = 0;
    n_acks = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (bus.vid_ack_o || bus.cpu_ack_o) begin
        checks++;
        if (bus.vid_ack_o && bus.cpu_ack_o) begin
          errors++;
          $display("FAIL contention_both_ack: cycle %0d vack=1 cack=1, required one", cyc);
        end
        owner = bus.cpu_ack_o ? 1 : 0;
        n_acks++;
        checks++;
        if (owner == last_owner || cyc - last_cyc != 2) begin
          errors++;
          $display("FAIL contention_order: cycle %0d owner=%0d gap=%0d, required owner=%0d gap=2",
                   cyc, owner, cyc - last_cyc, 1 - last_owner);
        end
        checks++;
        if (owner == 0) begin
          if (bus.vid_data_o !== ref_mem[va]) begin
            errors++;
            $display("FAIL contention_vdata: addr=%h data=%h, required %h", va, bus.vid_data_o, ref_mem[va]);
          end
          va = win();
          bus.vid_addr_i = va;
        end else begin
          if (bus.cpu_rdata_o !== ref_mem[ca]) begin
            errors++;
            $display("FAIL contention_cdata: addr=%h data=%h, required %h", ca, bus.cpu_rdata_o, ref_mem[ca]);
          end
          ca = win();
          bus.cpu_addr_i = ca;
        end
        last_owner = owner;
        last_cyc = cyc;
      end
    end
    checks++;
    if (n_acks != 10) begin errors++; $display("FAIL contention_count: acks=%0d, required 10", n_acks); end
    $display("txn contention: %0d alternating acks", n_acks);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] wd [4];
    int we_cnt [4];
    int widx;
    bit prev_we;
    bit ok;
    logic [DW-1:0] rd;
    logic [AW-1:0] va;
    for (int i = 0; i < 4; i++) begin
      wd[i] = DW'($urandom);
      we_cnt[i] = 0;
    end
    va = win();
    bus.vid_req_i = 1'b1;
    bus.vid_addr_i = va;
    widx = 0;
    bus.cpu_req_i = 1'b1;
    bus.cpu_we_i = 1'b1;
    bus.cpu_addr_i = '0;
    bus.cpu_wdata_i = wd[0];
    prev_we = 1'b0;
    for (int cyc = 0; cyc < 60 && widx < 4; cyc++) begin
      @(negedge clk);
      if (prev_we) begin
        checks++;
        if (!bus.cpu_ack_o || bus.ram_we_o) begin
          errors++;
          $display("FAIL b2b_we_slot: after we, cack=%b we=%b, required 1 0", bus.cpu_ack_o, bus.ram_we_o);
        end
      end
      if (bus.ram_we_o) begin
        checks++;
        if (bus.ram_addr_o > 16'd3 || bus.ram_wdata_o !== wd[bus.ram_addr_o[1:0]]) begin
          errors++;
          $display("FAIL b2b_wdata: addr=%h wdata=%h, required addr<=3 data for that addr", bus.ram_addr_o, bus.ram_wdata_o);
        end else begin
          we_cnt[bus.ram_addr_o[1:0]]++;
        end
      end
      prev_we = bus.ram_we_o;
      if (bus.vid_ack_o) begin
        checks++;
        if (bus.vid_data_o !== ref_mem[va]) begin
          errors++;
          $display("FAIL b2b_vdata: addr=%h data=%h, required %h", va, bus.vid_data_o, ref_mem[va]);
        end
        va = win();
        bus.vid_addr_i = va;
      end
      if (bus.cpu_ack_o) begin
        ref_mem[AW'(widx)] = wd[widx];
        widx++;
        if (widx < 4) begin
          bus.cpu_addr_i = AW'(widx);
          bus.cpu_wdata_i = wd[widx];
        end else begin
          bus.cpu_req_i = 1'b0;
        end
      end
    end
    checks++;
    if (widx != 4) begin errors++; $display("FAIL b2b_acks: writes acked=%0d, required 4", widx); end
    drain();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (we_cnt[i] != 1) begin errors++; $display("FAIL b2b_we_count: addr=%0d pulses=%0d, required 1", i, we_cnt[i]); end
      cpu_access(1'b0, AW'(i), '0, rd, ok);
      checks++;
      if (!ok || rd !== wd[i]) begin
        errors++;
        $display("FAIL b2b_readback: addr=%0d ack=%b data=%h, required 1 %h", i, ok, rd, wd[i]);
      end
      $display("txn b2b: addr=%0d wrote %h read %h", i, wd[i], rd);
    end
    drain();
  endtask

  task automatic test_random();
    bit vdone, cdone;
    vdone = 1'b0;
    cdone = 1'b0;
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          int gap, lat;
          bit got;
          logic [AW-1:0] a;
          gap = $urandom_range(2);
          a = win();
          if (gap > 0) begin
            bus.vid_req_i = 1'b0;
            repeat (gap) @(negedge clk);
          end
          bus.vid_req_i = 1'b1;
          bus.vid_addr_i = a;
          got = 1'b0;
          lat = 0;
          for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (bus.vid_ack_o) begin got = 1'b1; lat = k; end
          end
          checks++;
          if (!got || lat > 5) begin
            errors++;
            $display("FAIL rand_vid_latency: ack=%b cycles=%0d, required ack within 5", got, lat);
          end
          if (got) begin
            checks++;
            if (bus.vid_data_o !== ref_mem[a]) begin
              errors++;
              $display("FAIL rand_vid_data: addr=%h data=%h, required %h", a, bus.vid_data_o, ref_mem[a]);
            end
            $display("txn rand vid rd addr=%h data=%h lat=%0d", a, bus.vid_data_o, lat);
          end
        end
        bus.vid_req_i = 1'b0;
        vdone = 1'b1;
      end
      begin
        for (int n = 0; n < 30; n++) begin
          int gap, lat;
          bit got, we;
          logic [AW-1:0] a;
          logic [DW-1:0] d;
          gap = $urandom_range(2);
          a = win();
          d = DW'($urandom);
          we = 1'($urandom_range(1));
          if (gap > 0) begin
            bus.cpu_req_i = 1'b0;
            repeat (gap) @(negedge clk);
          end
          bus.cpu_req_i = 1'b1;
          bus.cpu_we_i = we;
          bus.cpu_addr_i = a;
          bus.cpu_wdata_i = d;
          got = 1'b0;
          lat = 0;
          for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (bus.cpu_ack_o) begin got = 1'b1; lat = k; end
          end
          checks++;
          if (!got || lat > 5) begin
            errors++;
            $display("FAIL rand_cpu_latency: ack=%b cycles=%0d, required ack within 5", got, lat);
          end
          if (got && we) begin
            ref_mem[a] = d;
            $display("txn rand cpu wr addr=%h data=%h lat=%0d", a, d, lat);
          end else if (got) begin
            checks++;
            if (bus.cpu_rdata_o !== ref_mem[a]) begin
              errors++;
              $display("FAIL rand_cpu_data: addr=%h data=%h, required %h", a, bus.cpu_rdata_o, ref_mem[a]);
            end
            $display("txn rand cpu rd addr=%h data=%h lat=%0d", a, bus.cpu_rdata_o, lat);
          end
        end
        bus.cpu_req_i = 1'b0;
        cdone = 1'b1;
      end
      begin
        bit pw;
        pw = 1'b0;
        for (int t = 0; t < 2000 && !(vdone && cdone); t++) begin
          @(negedge clk);
          if (bus.vid_ack_o || bus.cpu_ack_o) begin
            checks++;
            if (bus.vid_ack_o && bus.cpu_ack_o) begin
              errors++;
              $display("FAIL rand_ack_exclusive: vack=1 cack=1, required one");
            end
          end
          if (pw) begin
            checks++;
            if (bus.ram_we_o || !bus.cpu_ack_o) begin
              errors++;
              $display("FAIL rand_we_pulse: after we, we=%b cack=%b, required 0 1", bus.ram_we_o, bus.cpu_ack_o);
            end
          end
          pw = bus.ram_we_o;
        end
      end
    join
    drain();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_video_read();
    test_cpu_write_read();
    test_simultaneous();
    test_contention();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
